// File: rtl/pc_redirect_unit.sv
// Fetch PC and control-flow redirect: resolves BEQ/BNE/J/JR from execute-stage controls,
// drives the next fetch address, a one-cycle flush bubble, halt state and branch statistics.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_eq,
  input  logic             branch_ne,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic             zero_flag,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      imm,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic             flush,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken
);

  typedef enum logic [1:0] {StRun, StFlush, StHalted} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e      state;
  logic        taken;
  logic        is_branch;
  logic        jr_misaligned;
  logic [31:0] ex_pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] seq_pc;

  always_comb begin
    taken         = (branch_eq & zero_flag) | (branch_ne & ~zero_flag);
    is_branch     = branch_eq | branch_ne;
    jr_misaligned = jump_reg & (jr_target[1:0] != 2'b00);
    ex_pc4        = ex_pc + 32'd4;
    br_tgt        = ex_pc4 + (imm << 2);
    j_tgt         = {ex_pc4[31:28], jump_index, 2'b00};
    seq_pc        = pc + 32'd4;
  end

  // flush and halted are registered copies of the state decode, updated with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StRun;
      pc           <= RESET_PC;
      flush        <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      br_total     <= '0;
      br_taken     <= '0;
    end else begin
      unique case (state)
        StRun: begin
          if (halt_req) begin
            state  <= StHalted;
            halted <= 1'b1;
          end else if (jr_misaligned) begin
            state        <= StHalted;
            halted       <= 1'b1;
            misalign_err <= 1'b1;
          end else if (jump_reg) begin
            pc    <= jr_target;
            state <= StFlush;
            flush <= 1'b1;
          end else if (jump) begin
            pc    <= j_tgt;
            state <= StFlush;
            flush <= 1'b1;
          end else begin
            if (is_branch && br_total != CNT_MAX) br_total <= br_total + CNT_ONE;
            if (taken && br_taken != CNT_MAX) br_taken <= br_taken + CNT_ONE;
            if (taken) begin
              pc    <= br_tgt;
              state <= StFlush;
              flush <= 1'b1;
            end else if (!stall) begin
              pc <= seq_pc;
            end
          end
        end
        StFlush: begin
          // Execute slot is a bubble: only stall matters here.
          if (!stall) pc <= seq_pc;
          state <= StRun;
          flush <= 1'b0;
        end
        StHalted: begin
          state <= StHalted;
        end
        default: begin
          state  <= StRun;
          flush  <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: vector table for the main redirect paths plus
// hand-written sequences for halt, async reset, wrap and counter saturation.
module tb_pc_redirect_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, halt_req, branch_eq, branch_ne, jump, jump_reg, zero_flag;
  logic [31:0]   ex_pc, imm, jr_target;
  logic [25:0]   jump_index;
  logic [31:0]   pc;
  logic          flush, halted, misalign_err;
  logic [CW-1:0] br_total, br_taken;

  int n_vec = 0;
  int n_bad = 0;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .branch_eq(branch_eq),
    .branch_ne(branch_ne), .jump(jump), .jump_reg(jump_reg), .zero_flag(zero_flag),
    .ex_pc(ex_pc), .imm(imm), .jump_index(jump_index), .jr_target(jr_target), .pc(pc),
    .flush(flush), .halted(halted), .misalign_err(misalign_err), .br_total(br_total),
    .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, halt, beq, bne, jmp, jr, zero;
    logic [31:0] ex_pc, imm;
    logic [25:0] jidx;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic        e_flush;
    int          e_total, e_taken;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_flush,
                         input logic e_halted, input logic e_mis, input int e_tot,
                         input int e_tk);
    n_vec++;
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, e_halted});
    chk({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, e_mis});
    chk({tag, " br_total"}, {28'd0, br_total}, e_tot);
    chk({tag, " br_taken"}, {28'd0, br_taken}, e_tk);
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; branch_eq = 0; branch_ne = 0; jump = 0; jump_reg = 0;
    zero_flag = 0; ex_pc = '0; imm = '0; jump_index = '0; jr_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            st h eq ne j jr z  ex_pc         imm           jidx    jrt          e_pc         fl tot tk
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h4,        0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h8,        0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'hC,        0, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 1, 32'h40,      32'hFFFF_FFFC, 26'h0, 32'h0,       32'h34,       1, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h38,       0, 1, 1};
    vecs[5]  = '{0, 0, 1, 0, 0, 0, 0, 32'h40,      32'hFFFF_FFFC, 26'h0, 32'h0,       32'h3C,       0, 2, 1};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 0, 32'h100,     32'h8,        26'h0,  32'h0,       32'h124,      1, 3, 2};
    vecs[7]  = '{0, 0, 1, 0, 1, 1, 1, 32'h100,     32'h8,        26'h5,  32'h400,     32'h128,      0, 3, 2};
    vecs[8]  = '{1, 0, 0, 0, 1, 0, 0, 32'h1000_0000, 32'h0,      26'h10, 32'h0,       32'h1000_0040, 1, 3, 2};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h1000_0040, 0, 3, 2};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h1000_0040, 0, 3, 2};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h1000_0044, 0, 3, 2};
    vecs[12] = '{0, 0, 1, 1, 0, 0, 1, 32'h200,     32'h1,        26'h0,  32'h0,       32'h208,      1, 4, 3};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h20C,      0, 4, 3};
    vecs[14] = '{0, 0, 1, 0, 1, 0, 1, 32'h2000_0000, 32'h0,      26'h3,  32'h0,       32'h2000_000C, 1, 4, 3};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h2000_0010, 0, 4, 3};
    vecs[16] = '{0, 0, 0, 0, 1, 1, 0, 32'h0,       32'h0,        26'h7,  32'h200,     32'h200,      1, 4, 3};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,       32'h0,        26'h0,  32'h0,       32'h204,      0, 4, 3};

    idle();
    rst = 1;
    #2;
    chk_all("reset", 32'h0, 0, 0, 0, 0, 0);
    #10;
    rst = 0;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; halt_req = vecs[i].halt; branch_eq = vecs[i].beq;
      branch_ne = vecs[i].bne; jump = vecs[i].jmp; jump_reg = vecs[i].jr;
      zero_flag = vecs[i].zero; ex_pc = vecs[i].ex_pc; imm = vecs[i].imm;
      jump_index = vecs[i].jidx; jr_target = vecs[i].jrt;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flush, 0, 0,
              vecs[i].e_total, vecs[i].e_taken);
    end

    // Misaligned JR halts and freezes everything.
    idle(); jump_reg = 1; jr_target = 32'h202;
    step();
    chk_all("jr_misalign", 32'h204, 0, 1, 1, 4, 3);
    for (int k = 0; k < 5; k++) begin
      stall = 1'($urandom); halt_req = 1'($urandom); branch_eq = 1; branch_ne = 1;
      jump = 1; jump_reg = 1'($urandom); zero_flag = 1'($urandom);
      jr_target = $urandom; jump_index = 26'($urandom); ex_pc = $urandom;
      step();
      chk_all($sformatf("halt_frozen%0d", k), 32'h204, 0, 1, 1, 4, 3);
    end

    // Asynchronous reset between edges.
    #2 rst = 1;
    #1 chk_all("async_reset", 32'h0, 0, 0, 0, 0, 0);
    #1 rst = 0;
    idle();

    // halt_req beats a concurrent jump; halt persists after request drops.
    halt_req = 1; jump = 1; jump_index = 26'h100;
    step();
    chk_all("halt_req", 32'h0, 0, 1, 0, 0, 0);
    idle();
    step();
    chk_all("halt_hold", 32'h0, 0, 1, 0, 0, 0);

    // Reset during FLUSH drops the pending state.
    #2 rst = 1;
    #2 rst = 0;
    jump_reg = 1; jr_target = 32'h80;
    step();
    chk_all("jr_pre_rst", 32'h80, 1, 0, 0, 0, 0);
    #2 rst = 1;
    #1 chk_all("rst_in_flush", 32'h0, 0, 0, 0, 0, 0);
    #1 rst = 0;
    idle();
    step();
    chk_all("after_flush_rst", 32'h4, 0, 0, 0, 0, 0);

    // PC wrap-around.
    jump_reg = 1; jr_target = 32'hFFFF_FFF8;
    step();
    idle();
    step();
    chk_all("wrap_pre", 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    step();
    chk_all("wrap", 32'h0, 0, 0, 0, 0, 0);

    // Counter saturation at 4 bits.
    for (int k = 0; k < 20; k++) begin
      idle(); branch_eq = 1; zero_flag = 1; ex_pc = 32'h10; imm = 32'h0;
      step();
      idle();
      step();
      if (k == 14) chk_all("sat15", 32'h18, 0, 0, 0, 15, 15);
    end
    chk_all("sat20", 32'h18, 0, 0, 0, 15, 15);
    branch_ne = 1; zero_flag = 1;
    step();
    idle();
    chk_all("sat_nt", 32'h1C, 0, 0, 0, 15, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
